// File: rtl/ls193_pkg.sv
// Shared definitions for the 74LS193 counter driver: command encodings,
// controller states and synchronizer depth.
package ls193_pkg;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR_ACT,
    LOAD_ACT,
    PULSE_LO,
    PULSE_HI,
    SETTLE,
    CHECK
  } state_t;

  // Model of one count step on the device, wrapping modulo 16.
  function automatic logic [3:0] step4(input logic [3:0] q, input op_t op);
    return (op == OP_DOWN) ? q - 4'd1 : q + 4'd1;
  endfunction

endpackage

// File: rtl/ls193_sync2.sv
// Multi-flop synchronizer for pin inputs arriving asynchronously to clk.
module ls193_sync2
  import ls193_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_DEPTH];

  always_ff @(posedge clk) begin
    stage[0] <= d;
    for (int unsigned i = 1; i < SYNC_DEPTH; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/ls193_driver.sv
// Command-driven exerciser for a 74LS193 up/down counter: pulses the device
// pins, tracks the expected count and checks the read-back value.
module ls193_driver
  import ls193_pkg::*;
#(
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned SETTLE_W = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [3:0] CMD_DATA,
  output logic       UP,
  output logic       DOWN,
  output logic       LOAD_Bar,
  output logic       CLR,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       QA,
  input  logic       QB,
  input  logic       QC,
  input  logic       QD,
  input  logic       CO_Bar,
  input  logic       BO_Bar,
  output logic       DONE,
  output logic [3:0] Q_EXP,
  output logic       MISMATCH,
  output logic       CARRY,
  output logic       BORROW
);

  localparam logic [3:0] PW_M1 = 4'(PULSE_W - 1);
  localparam logic [3:0] SW_M1 = 4'(SETTLE_W - 1);

  state_t state, state_nxt;
  op_t    op_r, op_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] npulse, npulse_nxt;
  logic [3:0] preset, preset_nxt;
  logic [3:0] qexp_nxt;
  logic       done_nxt, mism_nxt, carry_nxt, borrow_nxt;
  logic       up_nxt, down_nxt, load_bar_nxt, clr_nxt;
  logic [5:0] pin_s;
  logic [3:0] q_s;
  logic       co_s, bo_s;
  logic [SYNC_DEPTH-1:0] lo_pipe;

  ls193_sync2 #(.WIDTH(6)) u_sync (
    .clk (CLK),
    .d   ({BO_Bar, CO_Bar, QD, QC, QB, QA}),
    .q   (pin_s)
  );

  assign q_s  = pin_s[3:0];
  assign co_s = pin_s[4];
  assign bo_s = pin_s[5];

  assign CMD_READY = (state == IDLE);
  assign {D, C, B, A} = preset;

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_r;
    cnt_nxt    = cnt;
    npulse_nxt = npulse;
    preset_nxt = preset;
    qexp_nxt   = Q_EXP;
    done_nxt   = 1'b0;
    mism_nxt   = MISMATCH;
    carry_nxt  = CARRY;
    borrow_nxt = BORROW;

    // The pulse-low window is delayed by the synchronizer depth so the
    // terminal-count flags are judged against the pulse that caused them.
    if (lo_pipe[SYNC_DEPTH-1]) begin
      if (op_r == OP_UP && !co_s)   carry_nxt  = 1'b1;
      if (op_r == OP_DOWN && !bo_s) borrow_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (CMD_VALID) begin
          op_nxt     = op_t'(CMD_OP);
          carry_nxt  = 1'b0;
          borrow_nxt = 1'b0;
          mism_nxt   = 1'b0;
          cnt_nxt    = PW_M1;
          unique case (op_nxt)
            OP_CLR: begin
              state_nxt = CLR_ACT;
              qexp_nxt  = '0;
            end
            OP_LOAD: begin
              state_nxt  = LOAD_ACT;
              preset_nxt = CMD_DATA;
              qexp_nxt   = CMD_DATA;
            end
            default: begin
              if (CMD_DATA == '0) begin
                state_nxt = SETTLE;
                cnt_nxt   = SW_M1;
              end else begin
                state_nxt  = PULSE_LO;
                npulse_nxt = CMD_DATA;
              end
            end
          endcase
        end
      end
      CLR_ACT, LOAD_ACT: begin
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = SW_M1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      PULSE_LO: begin
        if (cnt == '0) begin
          state_nxt = PULSE_HI;
          cnt_nxt   = PW_M1;
          qexp_nxt  = step4(Q_EXP, op_r);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      PULSE_HI: begin
        if (cnt == '0) begin
          npulse_nxt = npulse - 4'd1;
          if (npulse == 4'd1) begin
            state_nxt = SETTLE;
            cnt_nxt   = SW_M1;
          end else begin
            state_nxt = PULSE_LO;
            cnt_nxt   = PW_M1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = CHECK;
        else           cnt_nxt   = cnt - 4'd1;
      end
      CHECK: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        mism_nxt  = (q_s != Q_EXP);
      end
      default: state_nxt = IDLE;
    endcase

    up_nxt       = !(state_nxt == PULSE_LO && op_nxt == OP_UP);
    down_nxt     = !(state_nxt == PULSE_LO && op_nxt == OP_DOWN);
    load_bar_nxt = (state_nxt != LOAD_ACT);
    clr_nxt      = (state_nxt == CLR_ACT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      op_r     <= OP_CLR;
      cnt      <= '0;
      npulse   <= '0;
      preset   <= '0;
      Q_EXP    <= '0;
      DONE     <= 1'b0;
      MISMATCH <= 1'b0;
      CARRY    <= 1'b0;
      BORROW   <= 1'b0;
      UP       <= 1'b1;
      DOWN     <= 1'b1;
      LOAD_Bar <= 1'b1;
      CLR      <= 1'b0;
      lo_pipe  <= '0;
    end else begin
      state    <= state_nxt;
      op_r     <= op_nxt;
      cnt      <= cnt_nxt;
      npulse   <= npulse_nxt;
      preset   <= preset_nxt;
      Q_EXP    <= qexp_nxt;
      DONE     <= done_nxt;
      MISMATCH <= mism_nxt;
      CARRY    <= carry_nxt;
      BORROW   <= borrow_nxt;
      UP       <= up_nxt;
      DOWN     <= down_nxt;
      LOAD_Bar <= load_bar_nxt;
      CLR      <= clr_nxt;
      lo_pipe  <= {lo_pipe[SYNC_DEPTH-2:0], ~(UP & DOWN)};
    end
  end

endmodule

// File: tb/tb_ls193_driver.sv
// Bench for ls193_driver: drives commands against a behavioural 74LS193
// and checks results at DONE through an expected-result queue.
module tb_ls193_driver;

  localparam int PW = 2;
  localparam int SW = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [3:0] CMD_DATA = 4'h0;
  logic       UP, DOWN, LOAD_Bar, CLR, A, B, C, D;
  logic       QA, QB, QC, QD, CO_Bar, BO_Bar;
  logic       DONE, MISMATCH, CARRY, BORROW;
  logic [3:0] Q_EXP;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ls193_driver #(.PULSE_W(PW), .SETTLE_W(SW)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .UP(UP), .DOWN(DOWN),
    .LOAD_Bar(LOAD_Bar), .CLR(CLR), .A(A), .B(B), .C(C), .D(D),
    .QA(QA), .QB(QB), .QC(QC), .QD(QD), .CO_Bar(CO_Bar), .BO_Bar(BO_Bar),
    .DONE(DONE), .Q_EXP(Q_EXP), .MISMATCH(MISMATCH), .CARRY(CARRY),
    .BORROW(BORROW)
  );

  // Behavioural 74LS193: async clear/load, counts on rising UP or DOWN.
  logic [3:0] cnt_m = 4'h0;
  logic up_q = 1'b1, dn_q = 1'b1;
  logic qb_stuck = 1'b0;
  int   up_edges = 0, dn_edges = 0;

  always @(UP, DOWN, CLR, LOAD_Bar, A, B, C, D) begin
    if (CLR === 1'b1) cnt_m = 4'h0;
    else if (LOAD_Bar === 1'b0) cnt_m = {D, C, B, A};
    else if (UP === 1'b1 && up_q === 1'b0 && DOWN === 1'b1) cnt_m = cnt_m + 4'd1;
    else if (DOWN === 1'b1 && dn_q === 1'b0 && UP === 1'b1) cnt_m = cnt_m - 4'd1;
    up_q = UP;
    dn_q = DOWN;
  end

  always @(posedge UP) up_edges++;
  always @(posedge DOWN) dn_edges++;

  assign QA = cnt_m[0];
  assign QB = cnt_m[1] & ~qb_stuck;
  assign QC = cnt_m[2];
  assign QD = cnt_m[3];
  assign CO_Bar = !(cnt_m == 4'hF && UP === 1'b0);
  assign BO_Bar = !(cnt_m == 4'h0 && DOWN === 1'b0);

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic       fault;
    logic [3:0] q;
    logic       c, b, m;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       c, b, m;
    int         lat;
    int         edges;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   cyc, up0, dn0;
    bit   got;
    string tag;
    tag = $sformatf("v%0d", idx);
    qb_stuck = v.fault;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = v.op;
    CMD_DATA  = v.data;
    e.q = v.q; e.c = v.c; e.b = v.b; e.m = v.m;
    e.edges = (v.op[1]) ? int'(v.data) : 0;
    e.lat = (v.op[1]) ? 1 + 2 * PW * int'(v.data) + SW + 1 : 1 + PW + SW + 1;
    sb.push_back(e);
    up0 = up_edges;
    dn0 = dn_edges;
    chk({tag, "_ready"}, CMD_READY, 1'b1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, CMD_READY, 1'b0);
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (DONE === 1'b1) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    e = sb.pop_front();
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_q_exp"}, Q_EXP, e.q);
    chk({tag, "_carry"}, CARRY, e.c);
    chk({tag, "_borrow"}, BORROW, e.b);
    chk({tag, "_mismatch"}, MISMATCH, e.m);
    if (v.op == 2'b10) chk({tag, "_up_edges"}, up_edges - up0, e.edges);
    if (v.op == 2'b11) chk({tag, "_dn_edges"}, dn_edges - dn0, e.edges);
    if (v.op == 2'b01) chk({tag, "_preset"}, {D, C, B, A}, v.data);
    @(posedge CLK); #1;
    chk({tag, "_done_1cyc"}, DONE, 1'b0);
    chk({tag, "_flags_hold"}, {CARRY, BORROW, MISMATCH}, {e.c, e.b, e.m});
  endtask

  initial begin
    int  n_fall, done_seen;
    logic prev;

    //           op     data  flt   q     c     b     m
    tbl[0]  = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 4'hA, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 4'h3, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 4'hE, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 4'h3, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 4'h2, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'b10, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'b10, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{2'b11, 4'h1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 4'h2, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{2'b00, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{2'b01, 4'h5, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0};

    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_ready", CMD_READY, 1'b1);
    chk("rst_pins", {UP, DOWN, LOAD_Bar, CLR}, 4'b1110);
    chk("rst_preset", {D, C, B, A}, 4'h0);
    chk("rst_q_exp", Q_EXP, 4'h0);
    chk("rst_status", {DONE, MISMATCH, CARRY, BORROW}, 4'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

    // Reset during the second pulse of a count-up by 5.
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = 2'b10;
    CMD_DATA  = 4'h5;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    n_fall = 0;
    prev = 1'b1;
    for (int i = 0; i < 100 && n_fall < 2; i++) begin
      @(negedge CLK);
      if (prev && !UP) n_fall++;
      prev = UP;
    end
    chk("mid_pulse2_seen", n_fall, 2);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mid_up_idle", UP, 1'b1);
    chk("mid_pins_idle", {DOWN, LOAD_Bar, CLR}, 3'b110);
    chk("mid_done", DONE, 1'b0);
    chk("mid_ready", CMD_READY, 1'b1);
    chk("mid_q_exp", Q_EXP, 4'h0);
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) done_seen++;
    end
    chk("mid_no_done", done_seen, 0);
    chk("mid_still_ready", CMD_READY, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls193_driver.md
LS193_DRIVER -- requirements
Module: ls193_driver

Interface
REQ-001 SHALL have parameter PULSE_W, default 2, meaning the number of CLK cycles each UP/DOWN/LOAD_Bar/CLR pulse is held active (legal range 1..15).
REQ-002 SHALL have parameter SETTLE_W, default 3, meaning the number of CLK cycles waited after the last pulse before checking (legal range 3..15).
REQ-003 SHALL have one clock and one reset: CLK input 1, the single clock; RST input 1, a synchronous, active-high reset.
REQ-004 SHALL have port CMD_VALID input 1, meaning a command is offered.
REQ-005 SHALL have port CMD_READY output 1, meaning the driver accepts a command; transfer occurs when CMD_VALID&CMD_READY at a CLK edge.
REQ-006 SHALL have port CMD_OP input 2, decoded as 00 clear, 01 load, 10 count up, 11 count down.
REQ-007 SHALL have port CMD_DATA input 4, carrying the load value (op 01) or the pulse count N (ops 10/11); it is ignored for op 00.
REQ-008 SHALL have pin outputs UP, DOWN, LOAD_Bar output 1 each (idle high) and CLR output 1 (idle low).
REQ-009 SHALL have pin outputs A, B, C, D output 1 each, the preset value, with D as MSB.
REQ-010 SHALL have pin inputs QA, QB, QC, QD, CO_Bar, BO_Bar input 1 each, asynchronous to CLK and driven by the counter device.
REQ-011 SHALL have status outputs DONE output 1 (one-cycle pulse), Q_EXP output 4 (model count), MISMATCH output 1, CARRY output 1 and BORROW output 1.

Function
REQ-012 SHALL pass every pin input through a 2-flop synchronizer before any use.
REQ-013 SHALL implement the FSM states IDLE, CLR_ACT, LOAD_ACT, PULSE_LO, PULSE_HI, SETTLE and CHECK.
REQ-014 SHALL drive CMD_READY high only in IDLE; on accept it clears CARRY, BORROW and MISMATCH and latches CMD_OP and CMD_DATA.
REQ-015 SHALL handle op 00 by going to CLR_ACT with CLR=1 for PULSE_W cycles and setting Q_EXP=0, then going to SETTLE.
REQ-016 SHALL handle op 01 by driving A..D=CMD_DATA from the accept edge onward and going to LOAD_ACT with LOAD_Bar=0 for PULSE_W cycles, setting Q_EXP=CMD_DATA, then going to SETTLE.
REQ-017 SHALL leave A..D holding the last loaded value until the next load.
REQ-018 SHALL handle op 10/11 with N>0 by running N pulses, each consisting of PULSE_LO (selected line low for PULSE_W cycles) followed by PULSE_HI (line high for PULSE_W cycles).
REQ-019 SHALL drive UP for op 10 and DOWN for op 11, while the unselected line stays high throughout.
REQ-020 SHALL update Q_EXP on each low-to-high return of the pulse line, modulo 16: 15+1=0 and 0-1=15.
REQ-021 SHALL, for op 10/11 with N=0, issue no pulses and go directly to SETTLE.
REQ-022 SHALL set CARRY (op 10) or BORROW (op 11) if the synchronized CO_Bar or BO_Bar respectively is sampled low during any PULSE_LO cycle of the command.
REQ-023 SHALL go from SETTLE (SETTLE_W cycles) to CHECK for one cycle, set MISMATCH = (synchronized {QD,QC,QB,QA} != Q_EXP), pulse DONE, and return to IDLE.
REQ-024 SHALL hold CARRY, BORROW and MISMATCH from DONE until the next accept.
REQ-025 SHALL ignore CMD_VALID outside IDLE (no queuing), so the command latency for count ops is 1+2*PULSE_W*N+SETTLE_W+1 cycles from accept to DONE.

Reset
REQ-026 SHALL, when RST is high at a CLK edge, force the FSM to IDLE, UP=DOWN=LOAD_Bar=1, CLR=0, A..D=0, Q_EXP=0, and DONE=MISMATCH=CARRY=BORROW=0.
REQ-027 SHALL, on reset asserted mid-command, return all pins to idle levels within the same edge, issue no DONE, and discard the in-flight command.

Structure
REQ-028 SHALL place the op encodings, FSM state enum and synchronizer depth constant in a shared package ls193_pkg.
REQ-029 SHALL contain one sub-module, ls193_sync2 (2-flop synchronizer, width parameter), instantiated once over the 6 pin inputs.

Verification
REQ-030 SHALL cover: reset, clear, load 4'hA, count up N=3 with the driver connected to the counter model -> Q_EXP=4'hD, DONE pulses once, MISMATCH=0, CARRY=0.
REQ-031 SHALL cover: load 4'hE, count up N=3 -> 2 UP pulses then wrap, Q_EXP=4'h1, CARRY=1 (CO_Bar low on the pulse at count 15).
REQ-032 SHALL cover: load 4'h1, count down N=2 -> Q_EXP=4'hF, BORROW=1, MISMATCH=0.
REQ-033 SHALL cover: count up N=0 -> no UP edges, DONE after 1+SETTLE_W+1 cycles, Q_EXP unchanged.
REQ-034 SHALL cover: a forced QB stuck-at-0 fault, load 4'h2 -> MISMATCH=1 at DONE.
REQ-035 SHALL cover: RST asserted during the 2nd pulse of count up N=5 -> UP=1 next edge, no DONE, CMD_READY=1, Q_EXP=0.
